// File: rtl/cdc_2phase_core.sv
// Single-word valid/ready channel built on a 2-phase req/ack toggle handshake.
// req/ack cross between sides through SYNC_STAGES-deep synchronizer chains.
module cdc_2phase_core #(
  parameter type T           = logic,
  parameter int  SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_clr_i,
  input  T     src_data_i,
  input  logic src_valid_i,
  output logic src_ready_o,
  input  logic dst_clr_i,
  output T     dst_data_o,
  output logic dst_valid_o,
  input  logic dst_ready_i
);

  logic                   clr;
  logic                   src_req_q;
  T                       src_data_q;
  logic                   dst_ack_q;
  logic [SYNC_STAGES-1:0] req_sync;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   src_fire;
  logic                   dst_fire;

  // Clearing both sides together keeps req and ack phases aligned.
  assign clr = src_clr_i | dst_clr_i;

  assign src_ready_o = (src_req_q == ack_sync[SYNC_STAGES-1]);
  assign dst_valid_o = (req_sync[SYNC_STAGES-1] != dst_ack_q);
  assign dst_data_o  = src_data_q;

  assign src_fire = src_valid_i & src_ready_o;
  assign dst_fire = dst_valid_o & dst_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_req_q  <= 1'b0;
      src_data_q <= '0;
    end else if (clr) begin
      src_req_q  <= 1'b0;
      src_data_q <= '0;
    end else if (src_fire) begin
      src_req_q  <= ~src_req_q;
      src_data_q <= src_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dst_ack_q <= 1'b0;
    end else if (clr) begin
      dst_ack_q <= 1'b0;
    end else if (dst_fire) begin
      dst_ack_q <= ~dst_ack_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_sync <= '0;
      ack_sync <= '0;
    end else if (clr) begin
      req_sync <= '0;
      ack_sync <= '0;
    end else begin
      req_sync[0] <= src_req_q;
      ack_sync[0] <= dst_ack_q;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        req_sync[i] <= req_sync[i-1];
        ack_sync[i] <= ack_sync[i-1];
      end
    end
  end

endmodule

// File: tb/tb_cdc_2phase_core.sv
// Bench for cdc_2phase_core: directed timing checks plus a
// scoreboard monitor that checks every delivered word in order.
module tb_cdc_2phase_core;

  typedef logic [7:0] byte_t;

  logic  clk;
  logic  rst_ni;
  logic  src_clr;
  byte_t src_data;
  logic  src_valid;
  logic  src_ready;
  logic  dst_clr;
  byte_t dst_data;
  logic  dst_valid;
  logic  dst_ready;

  int    total = 0;
  int    bad   = 0;
  int    npop  = 0;
  byte_t exp_q[$];

  cdc_2phase_core #(
    .T           (byte_t),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .src_clr_i   (src_clr),
    .src_data_i  (src_data),
    .src_valid_i (src_valid),
    .src_ready_o (src_ready),
    .dst_clr_i   (dst_clr),
    .dst_data_o  (dst_data),
    .dst_valid_o (dst_valid),
    .dst_ready_i (dst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: expected words queued on handshake, checked on pop.
  always @(negedge clk) begin
    if (!rst_ni || src_clr || dst_clr) begin
      exp_q.delete();
    end else begin
      if (dst_valid && dst_ready) begin
        npop++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pop_unexpected: got %0h expected none", dst_data);
        end else begin
          byte_t e;
          e = exp_q.pop_front();
          if (dst_data !== e) begin
            bad++;
            $display("FAIL pop_data: got %0h expected %0h", dst_data, e);
          end
        end
      end
      if (src_valid && src_ready) exp_q.push_back(src_data);
    end
  end

  initial begin
    int sent;
    int cyc;
    int pop0;
    logic fire;

    rst_ni    = 1'b0;
    src_clr   = 1'b0;
    dst_clr   = 1'b0;
    src_data  = 8'h00;
    src_valid = 1'b0;
    dst_ready = 1'b0;
    #2;
    check("rst_ready", int'(src_ready), 1);
    check("rst_valid", int'(dst_valid), 0);
    check("rst_data", int'(dst_data), 0);
    step();
    step();
    rst_ni = 1'b1;
    step();

    // Latency: accept at E0, valid after E2.
    src_valid = 1'b1;
    src_data  = 8'hA5;
    step();
    src_valid = 1'b0;
    src_data  = 8'h00;
    check("e0_ready", int'(src_ready), 0);
    check("e0_valid", int'(dst_valid), 0);
    step();
    check("e1_valid", int'(dst_valid), 0);
    step();
    check("e2_valid", int'(dst_valid), 1);
    check("e2_data", int'(dst_data), 8'hA5);

    // Backpressure for 10 cycles.
    for (int i = 0; i < 10; i++) step();
    check("bp_valid", int'(dst_valid), 1);
    check("bp_data", int'(dst_data), 8'hA5);
    check("bp_ready", int'(src_ready), 0);

    // Pop at edge P.
    dst_ready = 1'b1;
    step();
    dst_ready = 1'b0;
    check("p_valid", int'(dst_valid), 0);
    check("p_data_kept", int'(dst_data), 8'hA5);
    check("p_ready", int'(src_ready), 0);
    step();
    check("p1_ready", int'(src_ready), 0);
    step();
    check("p2_ready", int'(src_ready), 1);
    check("pop_count", npop, 1);

    // Async reset mid-transfer.
    src_valid = 1'b1;
    src_data  = 8'h3C;
    step();
    src_valid = 1'b0;
    step();
    rst_ni = 1'b0;
    #1;
    check("mid_rst_ready", int'(src_ready), 1);
    check("mid_rst_valid", int'(dst_valid), 0);
    check("mid_rst_data", int'(dst_data), 0);
    step();
    rst_ni = 1'b1;
    step();

    // Synchronous clear while a word is in flight.
    src_valid = 1'b1;
    src_data  = 8'h5A;
    step();
    src_valid = 1'b0;
    src_clr   = 1'b1;
    dst_clr   = 1'b1;
    step();
    src_clr   = 1'b0;
    dst_clr   = 1'b0;
    check("clr_ready", int'(src_ready), 1);
    check("clr_valid", int'(dst_valid), 0);
    check("clr_data", int'(dst_data), 0);
    for (int i = 0; i < 4; i++) step();
    check("clr_quiet", int'(dst_valid), 0);

    pop0      = npop;
    dst_ready = 1'b1;
    src_valid = 1'b1;
    src_data  = 8'h77;
    step();
    src_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    dst_ready = 1'b0;
    check("after_clr_pops", npop - pop0, 1);

    // Streaming 0..99 with random valid/ready.
    pop0 = npop;
    sent = 0;
    cyc  = 0;
    fork
      begin
        while (sent < 100 && cyc < 20000) begin
          if (!src_valid && $urandom_range(0, 2) != 0) begin
            src_valid = 1'b1;
            src_data  = sent[7:0];
          end
          @(negedge clk);
          fire = src_valid && src_ready;
          step();
          cyc++;
          if (fire) begin
            sent++;
            src_valid = 1'b0;
          end
        end
        src_valid = 1'b0;
      end
      begin
        while (npop - pop0 < 100 && cyc < 20000) begin
          dst_ready = 1'($urandom_range(0, 1));
          step();
        end
        dst_ready = 1'b0;
      end
    join
    check("stream_sent", sent, 100);
    check("stream_pops", npop - pop0, 100);
    check("stream_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
